// File: rtl/game_pkg.sv
// game_pkg: shared motion state encoding and screen geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_DEAD   = 2'd2,
    ST_SPAWN  = 2'd3
  } motion_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/axis_clamp.sv
// axis_clamp: adds a signed delta to a screen coordinate and clamps the
// result into [lo, hi] and then into the legal screen range.
// hit_o is set when the sum falls below lo or touches/passes hi; touching
// counts so that a sprite resting exactly on the floor reports contact.
module axis_clamp #(
  parameter int POS_W = 10,
  parameter int DW    = 6
) (
  input  logic [POS_W-1:0]        pos_i,
  input  logic signed [DW-1:0]    delta_i,
  input  logic signed [POS_W+1:0] lo_i,
  input  logic signed [POS_W+1:0] hi_i,
  output logic [POS_W-1:0]        pos_o,
  output logic                    hit_o
);
  // Two guard bits: one for sign, one so pos near the top plus delta cannot wrap.
  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] PMAX = SW'((1 << POS_W) - 1);

  logic signed [SW-1:0] sum, lim;

  // Wide signed add, bound clamp, then saturate into [0, 2^POS_W-1].
  always_comb begin
    sum   = $signed({2'b00, pos_i}) + $signed({{(SW-DW){delta_i[DW-1]}}, delta_i});
    hit_o = (sum < lo_i) || (sum >= hi_i);
    lim   = sum;
    if (sum < lo_i)      lim = lo_i;
    else if (sum > hi_i) lim = hi_i;
    if (lim[SW-1])       lim = '0;
    else if (lim > PMAX) lim = PMAX;
    pos_o = lim[POS_W-1:0];
  end

endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame player physics (gravity, run/jump, collision
// clamping, horizontal scroll, death/respawn). One step per frame_tick.
// Optional build macro PLAYER_MOTION_VARJUMP_EN: releasing jump while still
// rising fast cuts the upward speed to a short hop.
module player_motion
  import game_pkg::*;
#(
  parameter int POS_W          = 10,
  parameter int WORLD_W        = 12,
  parameter int RUN_SPEED      = 2,
  parameter int JUMP_V0        = 9,
  parameter int TERM_V         = 4,
  parameter int GRAV_DIV       = 6,
  parameter int SPRITE_W       = 16,
  parameter int SPRITE_H       = 16,
  parameter int START_X        = 80,
  parameter int START_Y        = 100,
  parameter int SCROLL_X       = 320,
  parameter int WORLD_MAX      = 1420,
  parameter int DEATH_Y        = 460,
  parameter int RESPAWN_FRAMES = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_jump,
  input  logic               btn_down,
  input  logic [POS_W-1:0]   wall_left,
  input  logic [POS_W-1:0]   wall_right,
  input  logic [POS_W-1:0]   ceil_y,
  input  logic [POS_W-1:0]   floor_y,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic [WORLD_W-1:0] world_x,
  output logic signed [5:0]  vel_y,
  output logic               face_left,
  output logic               on_ground,
  output logic [1:0]         state,
  output logic               step_done,
  output logic               died
);
  localparam int SW = POS_W + 2;
  localparam int GW = $clog2(GRAV_DIV + 1);
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);
  localparam logic signed [5:0]    V_TERM  = 6'(TERM_V);
  localparam logic signed [5:0]    V_JUMP  = 6'(-JUMP_V0);
  localparam logic signed [5:0]    V_RUN   = 6'(RUN_SPEED);
`ifdef PLAYER_MOTION_VARJUMP_EN
  localparam logic signed [5:0]    V_SHORT = -6'sd2;
`endif
  localparam logic signed [SW-1:0] S_MIN   = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX   = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_SPR_W = SW'(SPRITE_W);
  localparam logic signed [SW-1:0] S_SPR_H = SW'(SPRITE_H);
  localparam logic [WORLD_W:0]     W_MAX   = (WORLD_W+1)'(WORLD_MAX);

  function automatic logic signed [SW-1:0] ext(input logic [POS_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  motion_state_t       st_q, st_d;
  logic [POS_W-1:0]    px_q, px_d, py_q, py_d, x_new, y_new;
  logic [WORLD_W-1:0]  wx_q, wx_d;
  logic [WORLD_W:0]    wsum;
  logic signed [5:0]   vy_q, vy_d, vg, dx;
  logic [GW-1:0]       gc_q, gc_d;
  logic [RW-1:0]       rc_q, rc_d;
  logic                face_q, face_d, step_q, died_q, died_d;
  logic                scroll, y_hit, x_hit_unused;
  logic signed [SW-1:0] x_lo, x_hi, y_lo, y_hi;

  // Horizontal intent and bounds: only the wall in the direction of travel applies.
  always_comb begin
    dx = '0;
    if (btn_right && !btn_left) dx = V_RUN;
    if (btn_left && !btn_right) dx = -V_RUN;
    x_lo   = dx[5] ? ext(wall_left) + SW'(1) : S_MIN;
    x_hi   = (!dx[5] && dx != '0) ? ext(wall_right) - S_SPR_W : S_MAX;
    // Rising checks the ceiling only, falling/resting checks the floor only.
    y_lo   = vy_q[5] ? ext(ceil_y) : S_MIN;
    y_hi   = vy_q[5] ? S_MAX : ext(floor_y) - S_SPR_H;
    scroll = !dx[5] && dx != '0 && px_q >= POS_W'(SCROLL_X) && wx_q < WORLD_W'(WORLD_MAX);
    wsum   = {1'b0, wx_q} + (WORLD_W+1)'(RUN_SPEED);
  end

  axis_clamp #(.POS_W(POS_W), .DW(6)) u_clamp_x (
    .pos_i(px_q), .delta_i(dx), .lo_i(x_lo), .hi_i(x_hi), .pos_o(x_new), .hit_o(x_hit_unused)
  );

  axis_clamp #(.POS_W(POS_W), .DW(6)) u_clamp_y (
    .pos_i(py_q), .delta_i(vy_q), .lo_i(y_lo), .hi_i(y_hi), .pos_o(y_new), .hit_o(y_hit)
  );

  // Next-state and per-tick physics; everything holds when no tick is present.
  always_comb begin
    st_d = st_q; px_d = px_q; py_d = py_q; wx_d = wx_q; vy_d = vy_q;
    face_d = face_q; gc_d = gc_q; rc_d = rc_q; died_d = 1'b0; vg = vy_q;
    if (frame_tick) begin
      unique case (st_q)
        ST_GROUND, ST_AIR: begin
          // Death is checked on the committed position, before any motion or landing.
          if (py_q >= POS_W'(DEATH_Y)) begin
            st_d = ST_DEAD; died_d = 1'b1; rc_d = '0;
          end else begin
            if (dx != '0) begin
              face_d = dx[5];
              if (scroll) wx_d = (wsum > W_MAX) ? W_MAX[WORLD_W-1:0] : wsum[WORLD_W-1:0];
              else        px_d = x_new;
            end
            if (st_q == ST_GROUND) begin
              // Jump is tested first so it wins over losing the floor.
              if (btn_jump) begin
                vy_d = V_JUMP; st_d = ST_AIR; gc_d = '0;
              end else if (ext(py_q) + S_SPR_H < ext(floor_y)) begin
                vy_d = '0; st_d = ST_AIR; gc_d = '0;
              end
            end else begin
              // Position moves by the velocity held at the start of the step.
              if (gc_q == GW'(GRAV_DIV - 1)) begin
                gc_d = '0;
                if (vy_q < V_TERM) vg = vy_q + 6'sd1;
              end else begin
                gc_d = gc_q + GW'(1);
              end
`ifdef PLAYER_MOTION_VARJUMP_EN
              if (!btn_jump && vy_q < V_SHORT) vg = V_SHORT;
`endif
              if (btn_down) vg = V_TERM;
              vy_d = vg;
              if (y_hit && !vy_q[5]) begin
                py_d = y_new; vy_d = '0; st_d = ST_GROUND; gc_d = '0;
              end else if (y_hit) begin
                py_d = (ceil_y == '1) ? ceil_y : ceil_y + POS_W'(1);
                vy_d = '0;
              end else begin
                py_d = y_new;
              end
            end
          end
        end
        ST_DEAD: begin
          if (rc_q == RW'(RESPAWN_FRAMES - 1)) begin
            rc_d = '0; st_d = ST_SPAWN;
            px_d = POS_W'(START_X); py_d = POS_W'(START_Y); wx_d = '0; vy_d = '0;
          end else begin
            rc_d = rc_q + RW'(1);
          end
        end
        ST_SPAWN: begin
          px_d = POS_W'(START_X); py_d = POS_W'(START_Y); wx_d = '0; vy_d = '0;
          st_d = ST_AIR; gc_d = '0;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset drops any step in flight along with its pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q <= ST_AIR; px_q <= POS_W'(START_X); py_q <= POS_W'(START_Y);
      wx_q <= '0; vy_q <= '0; face_q <= 1'b0; gc_q <= '0; rc_q <= '0;
      step_q <= 1'b0; died_q <= 1'b0;
    end else begin
      st_q <= st_d; px_q <= px_d; py_q <= py_d; wx_q <= wx_d; vy_q <= vy_d;
      face_q <= face_d; gc_q <= gc_d; rc_q <= rc_d;
      step_q <= frame_tick; died_q <= died_d;
    end
  end

  assign pos_x     = px_q;
  assign pos_y     = py_q;
  assign world_x   = wx_q;
  assign vel_y     = vy_q;
  assign face_left = face_q;
  assign on_ground = (st_q == ST_GROUND);
  assign state     = st_q;
  assign step_done = step_q;
  assign died      = died_q;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed checks of player_motion with default parameters.
module tb_player_motion;
  import game_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_tick, btn_left, btn_right, btn_jump, btn_down;
  logic [9:0]  wall_left, wall_right, ceil_y, floor_y, pos_x, pos_y;
  logic [11:0] world_x;
  logic signed [5:0] vel_y;
  logic        face_left, on_ground, step_done, died;
  logic [1:0]  state;
  int checks = 0, errors = 0, died_cnt = 0;

  always #5 Clk = ~Clk;

  player_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_down(btn_down),
    .wall_left(wall_left), .wall_right(wall_right), .ceil_y(ceil_y), .floor_y(floor_y),
    .pos_x(pos_x), .pos_y(pos_y), .world_x(world_x), .vel_y(vel_y),
    .face_left(face_left), .on_ground(on_ground), .state(state),
    .step_done(step_done), .died(died)
  );

  // One-cycle tick; outputs sampled on the falling edge after the step lands.
  task automatic tick();
    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    if (died === 1'b1) died_cnt++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; frame_tick = 1'b1;
    btn_left = 0; btn_right = 0; btn_jump = 0; btn_down = 0;
    wall_left = 10'd0; wall_right = 10'd639; ceil_y = 10'd0; floor_y = 10'd300;
    repeat (3) @(negedge Clk);
    frame_tick = 1'b0; Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (pos_x !== 10'd80) begin errors++; $display("FAIL reset_pos_x got %0d exp 80", pos_x); end
    checks++; if (pos_y !== 10'd100) begin errors++; $display("FAIL reset_pos_y got %0d exp 100", pos_y); end
    checks++; if (world_x !== 12'd0) begin errors++; $display("FAIL reset_world_x got %0d exp 0", world_x); end
    checks++; if (vel_y !== 6'sd0) begin errors++; $display("FAIL reset_vel_y got %0d exp 0", vel_y); end
    checks++; if (state !== ST_AIR) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, ST_AIR); end
    checks++; if ({face_left, on_ground, step_done, died} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {face_left, on_ground, step_done, died}); end
  endtask

  task automatic test_fall_land();
    int n;
    tick();
    checks++; if (state !== ST_AIR || step_done !== 1'b1) begin
      errors++; $display("FAIL first_tick state %0d step_done %b exp %0d 1", state, step_done, ST_AIR); end
    @(negedge Clk);
    checks++; if (step_done !== 1'b0 || pos_y !== 10'd100) begin
      errors++; $display("FAIL idle_hold step_done %b pos_y %0d exp 0 100", step_done, pos_y); end
    repeat (5) tick();
    checks++; if (vel_y !== 6'sd1 || pos_y !== 10'd100) begin
      errors++; $display("FAIL gravity_6 vel %0d pos_y %0d exp 1 100", vel_y, pos_y); end
    n = 0;
    while (state !== ST_GROUND && n < 400) begin tick(); n++; end
    checks++; if (state !== ST_GROUND || pos_y !== 10'd284 || vel_y !== 6'sd0 || on_ground !== 1'b1) begin
      errors++; $display("FAIL land state %0d pos_y %0d vel %0d exp %0d 284 0", state, pos_y, vel_y, ST_GROUND); end
  endtask

  task automatic test_jump();
    int n;
    btn_jump = 1'b1;
    tick();
    checks++; if (vel_y !== -6'sd9 || state !== ST_AIR || pos_y !== 10'd284) begin
      errors++; $display("FAIL jump_start vel %0d state %0d pos_y %0d exp -9 %0d 284", vel_y, state, pos_y, ST_AIR); end
    tick();
    checks++; if (pos_y !== 10'd275) begin errors++; $display("FAIL jump_rise pos_y %0d exp 275", pos_y); end
    n = 1;
    while (vel_y !== 6'sd0 && n < 100) begin tick(); n++; end
    checks++; if (n != 54 || pos_y !== 10'd14) begin
      errors++; $display("FAIL jump_apex ticks %0d pos_y %0d exp 54 14", n, pos_y); end
    btn_jump = 1'b0;
    n = 0;
    while (state !== ST_GROUND && n < 400) begin tick(); n++; end
    checks++; if (state !== ST_GROUND || pos_y !== 10'd284) begin
      errors++; $display("FAIL jump_land state %0d pos_y %0d exp %0d 284", state, pos_y, ST_GROUND); end
  endtask

  task automatic test_scroll();
    int n;
    btn_right = 1'b1;
    n = 0;
    while (pos_x < 10'd320 && n < 200) begin tick(); n++; end
    checks++; if (pos_x !== 10'd320 || world_x !== 12'd0) begin
      errors++; $display("FAIL reach_scroll pos_x %0d world %0d exp 320 0", pos_x, world_x); end
    n = 0;
    while (world_x < 12'd1418 && n < 800) begin tick(); n++; end
    checks++; if (world_x !== 12'd1418 || pos_x !== 10'd320) begin
      errors++; $display("FAIL scroll_run world %0d pos_x %0d exp 1418 320", world_x, pos_x); end
    tick();
    checks++; if (world_x !== 12'd1420 || pos_x !== 10'd320 || face_left !== 1'b0) begin
      errors++; $display("FAIL scroll_sat world %0d pos_x %0d face %b exp 1420 320 0", world_x, pos_x, face_left); end
    tick();
    checks++; if (world_x !== 12'd1420 || pos_x !== 10'd322) begin
      errors++; $display("FAIL scroll_end world %0d pos_x %0d exp 1420 322", world_x, pos_x); end
  endtask

  task automatic test_back_to_back();
    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk);
    checks++; if (pos_x !== 10'd324 || step_done !== 1'b1) begin
      errors++; $display("FAIL b2b_first pos_x %0d step_done %b exp 324 1", pos_x, step_done); end
    @(negedge Clk); frame_tick = 1'b0;
    checks++; if (pos_x !== 10'd326 || step_done !== 1'b1) begin
      errors++; $display("FAIL b2b_second pos_x %0d step_done %b exp 326 1", pos_x, step_done); end
    @(negedge Clk);
    checks++; if (pos_x !== 10'd326 || step_done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle pos_x %0d step_done %b exp 326 0", pos_x, step_done); end
  endtask

  task automatic test_walls();
    int n;
    btn_right = 1'b0; btn_left = 1'b1;
    tick();
    checks++; if (pos_x !== 10'd324 || face_left !== 1'b1) begin
      errors++; $display("FAIL move_left pos_x %0d face %b exp 324 1", pos_x, face_left); end
    btn_right = 1'b1;
    tick();
    checks++; if (pos_x !== 10'd324 || face_left !== 1'b1) begin
      errors++; $display("FAIL both_held pos_x %0d face %b exp 324 1", pos_x, face_left); end
    btn_right = 1'b0; wall_left = 10'd82;
    n = 0;
    while (pos_x !== 10'd83 && n < 200) begin tick(); n++; end
    checks++; if (pos_x !== 10'd83 || n != 121) begin
      errors++; $display("FAIL left_wall pos_x %0d ticks %0d exp 83 121", pos_x, n); end
    wall_left = 10'd0; wall_right = 10'd100; btn_left = 1'b0; btn_right = 1'b1;
    tick();
    checks++; if (pos_x !== 10'd84 || face_left !== 1'b0) begin
      errors++; $display("FAIL right_wall pos_x %0d face %b exp 84 0", pos_x, face_left); end
    tick();
    checks++; if (pos_x !== 10'd84) begin errors++; $display("FAIL right_wall_hold pos_x %0d exp 84", pos_x); end
    btn_right = 1'b0; wall_right = 10'd639;
  endtask

  task automatic test_ceiling();
    int n;
    ceil_y = 10'd280; btn_jump = 1'b1;
    tick();
    btn_jump = 1'b0;
    tick();
    checks++; if (pos_y !== 10'd281 || vel_y !== 6'sd0 || state !== ST_AIR) begin
      errors++; $display("FAIL ceiling pos_y %0d vel %0d state %0d exp 281 0 %0d", pos_y, vel_y, state, ST_AIR); end
    n = 0;
    while (state !== ST_GROUND && n < 100) begin tick(); n++; end
    checks++; if (state !== ST_GROUND || pos_y !== 10'd284) begin
      errors++; $display("FAIL ceiling_land state %0d pos_y %0d exp %0d 284", state, pos_y, ST_GROUND); end
    ceil_y = 10'd0;
  endtask

  task automatic test_varjump();
    int n;
    logic signed [5:0] exp_v;
`ifdef PLAYER_MOTION_VARJUMP_EN
    exp_v = -6'sd2;
`else
    exp_v = -6'sd8;
`endif
    btn_jump = 1'b1;
    repeat (7) tick();
    checks++; if (vel_y !== -6'sd8) begin errors++; $display("FAIL hold_jump vel %0d exp -8", vel_y); end
    btn_jump = 1'b0;
    tick();
    checks++; if (vel_y !== exp_v) begin errors++; $display("FAIL release_jump vel %0d exp %0d", vel_y, exp_v); end
    n = 0;
    while (state !== ST_GROUND && n < 400) begin tick(); n++; end
    checks++; if (state !== ST_GROUND || pos_y !== 10'd284) begin
      errors++; $display("FAIL varjump_land state %0d pos_y %0d exp %0d 284", state, pos_y, ST_GROUND); end
  endtask

  task automatic test_death();
    int n;
    died_cnt = 0; floor_y = 10'd600;
    n = 0;
    while (state !== ST_DEAD && n < 400) begin tick(); n++; end
    checks++; if (state !== ST_DEAD || died !== 1'b1 || pos_y !== 10'd460) begin
      errors++; $display("FAIL death state %0d died %b pos_y %0d exp %0d 1 460", state, died, pos_y, ST_DEAD); end
    @(negedge Clk);
    checks++; if (died !== 1'b0) begin errors++; $display("FAIL died_pulse died %b exp 0", died); end
    repeat (31) tick();
    checks++; if (state !== ST_DEAD || pos_y !== 10'd460) begin
      errors++; $display("FAIL dead_hold state %0d pos_y %0d exp %0d 460", state, pos_y, ST_DEAD); end
    tick();
    checks++; if (state !== ST_SPAWN || pos_x !== 10'd80 || pos_y !== 10'd100 || world_x !== 12'd0 || vel_y !== 6'sd0) begin
      errors++; $display("FAIL spawn state %0d pos %0d,%0d world %0d vel %0d exp %0d 80,100 0 0",
                         state, pos_x, pos_y, world_x, vel_y, ST_SPAWN); end
    tick();
    checks++; if (state !== ST_AIR || pos_x !== 10'd80 || pos_y !== 10'd100) begin
      errors++; $display("FAIL respawn_air state %0d pos %0d,%0d exp %0d 80,100", state, pos_x, pos_y, ST_AIR); end
    checks++; if (died_cnt != 1) begin errors++; $display("FAIL died_count got %0d exp 1", died_cnt); end
  endtask

  initial begin
    test_reset();
    test_fall_land();
    test_jump();
    test_scroll();
    test_back_to_back();
    test_walls();
    test_ceiling();
    test_varjump();
    test_death();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
